hazard_scoreboard: RTL and testbench

- Producer-side companion to the forwarding unit. Tracks every in-flight register write (EX, MEM and WB slots) as instructions issue from ID.
- Generates the load-use stall and the registered operand-select codes that the EX stage uses to pick ALU operands.
- Sits beside the ID/EX latch, is fed by decode and the memory-wait signal, and replaces the per-stage rd comparisons scattered through the datapath.

---
 rtl/hazard_scoreboard.sv | 188 ++++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Producer-side register-write scoreboard for a 5-stage pipeline.
//            Tracks the destination of every in-flight instruction in the
//            EX (S0), MEM (S1) and WB (S2) slots. It produces the load-use
//            stall and the registered EX operand-select codes:
//            0 = regfile, 1 = MEM ALU result, 2 = WB data.
// Ports    : CLK, nRST         clock, synchronous active-low reset
//            id_*              decoded instruction currently in ID
//            mem_wait          memory not ready; whole pipe frozen
//            flush             taken branch/jump; squash the ID instruction
//            stall_id          hold PC and IF/ID, bubble into EX
//            fwd_rs_ex/rt_ex   operand selects for the instruction in EX
//            sb_state          FSM state (RUN=0, LDSTALL=1, MWAIT=2)
//            ldstall_cnt       saturating load-use stall cycle counter
//            wait_cnt          saturating mem_wait cycle counter
// Options  : SB_STALL_CNT_EN   when defined, the two counters are built.
//                              Otherwise both ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_regWr,
    input  logic [4:0]       id_wsel,
    input  logic             id_memRead,
    input  logic             mem_wait,
    input  logic             flush,
    output logic             stall_id,
    output logic [2:0]       fwd_rs_ex,
    output logic [2:0]       fwd_rt_ex,
    output logic [1:0]       sb_state,
    output logic [CNT_W-1:0] ldstall_cnt,
    output logic [CNT_W-1:0] wait_cnt
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] wsel;
        logic       ld;
    } slot_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_MWAIT   = 2'd2
    } state_t;

    slot_t      s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    slot_t      w_id_entry;
    state_t     state_q, state_d;
    logic [2:0] fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
    logic       w_load_use;
    logic       w_ld_stall;

    // A slot only produces a value when it is a real register write to a
    // non-zero destination; equality with a non-zero wsel implies src != 0.
    function automatic logic slot_hits(input slot_t s, input logic [4:0] src);
        return s.v && s.wr && (s.wsel != 5'd0) && (s.wsel == src);
    endfunction

    // Youngest writer wins. An S0 load yields 0 because the load-use stall
    // turns the ID instruction into a bubble anyway. An S2 hit yields 0
    // because the regfile is written on the same edge the consumer enters EX.
    function automatic logic [2:0] fwd_code(input logic [4:0] src,
                                            input slot_t     a,
                                            input slot_t     b,
                                            input slot_t     c);
        logic [2:0] code;
        code = 3'd0;
        if (slot_hits(a, src)) begin
            code = a.ld ? 3'd0 : 3'd1;
        end else if (slot_hits(b, src)) begin
            code = 3'd2;
        end else if (slot_hits(c, src)) begin
            code = 3'd0;
        end
        return code;
    endfunction

    assign w_load_use = s0_q.v && s0_q.ld && s0_q.wr && (s0_q.wsel != 5'd0) &&
                        ((s0_q.wsel == id_rs) || (s0_q.wsel == id_rt));

    // Every cycle without mem_wait is an advance cycle, including the
    // LDSTALL cycle and the MWAIT exit cycle. They all evaluate hazards the
    // same way. With S0 a bubble during LDSTALL, a repeat stall cannot occur.
    always_comb begin
        s0_d       = s0_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        fwd_rs_d   = fwd_rs_q;
        fwd_rt_d   = fwd_rt_q;
        state_d    = state_q;
        w_id_entry = '0;
        w_ld_stall = 1'b0;
        stall_id   = 1'b0;

        if (mem_wait) begin
            stall_id = 1'b1;
            state_d  = ST_MWAIT;
        end else begin
            // A flush squashes the consumer, so it also cancels the stall.
            w_ld_stall = w_load_use && !flush;
            stall_id   = w_ld_stall;

            if (id_valid && !w_ld_stall && !flush) begin
                w_id_entry.v    = 1'b1;
                w_id_entry.wr   = id_regWr;
                w_id_entry.wsel = id_wsel;
                w_id_entry.ld   = id_memRead;
            end

            s0_d = w_id_entry;
            s1_d = s0_q;
            s2_d = s1_q;

            fwd_rs_d = w_id_entry.v ? fwd_code(id_rs, s0_q, s1_q, s2_q) : 3'd0;
            fwd_rt_d = w_id_entry.v ? fwd_code(id_rt, s0_q, s1_q, s2_q) : 3'd0;

            state_d = w_ld_stall ? ST_LDSTALL : ST_RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            s0_q     <= '0;
            s1_q     <= '0;
            s2_q     <= '0;
            fwd_rs_q <= 3'd0;
            fwd_rt_q <= 3'd0;
            state_q  <= ST_RUN;
        end else begin
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            fwd_rs_q <= fwd_rs_d;
            fwd_rt_q <= fwd_rt_d;
            state_q  <= state_d;
        end
    end

    assign fwd_rs_ex = fwd_rs_q;
    assign fwd_rt_ex = fwd_rt_q;
    assign sb_state  = state_q;

`ifdef SB_STALL_CNT_EN
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] ldstall_cnt_q, ldstall_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        ldstall_cnt_d = ldstall_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        if (w_ld_stall && (ldstall_cnt_q != '1)) begin
            ldstall_cnt_d = ldstall_cnt_q + C_CNT_ONE;
        end
        if ((state_q == ST_MWAIT) && (wait_cnt_q != '1)) begin
            wait_cnt_d = wait_cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ldstall_cnt_q <= '0;
            wait_cnt_q    <= '0;
        end else begin
            ldstall_cnt_q <= ldstall_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign ldstall_cnt = ldstall_cnt_q;
    assign wait_cnt    = wait_cnt_q;
`else
    assign ldstall_cnt = '0;
    assign wait_cnt    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Self-checking bench for hazard_scoreboard. A directed vector
//            table covers ALU chains, load-use, $0, flush, mem_wait and reset
//            in MWAIT. A randomized phase compares against an in-flight
//            instruction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int CNT_W = 16;
`ifdef SB_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             nRST;
    logic             id_valid;
    logic [4:0]       id_rs, id_rt, id_wsel;
    logic             id_regWr, id_memRead;
    logic             mem_wait, flush;
    logic             stall_id;
    logic [2:0]       fwd_rs_ex, fwd_rt_ex;
    logic [1:0]       sb_state;
    logic [CNT_W-1:0] ldstall_cnt, wait_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_regWr   (id_regWr),
        .id_wsel    (id_wsel),
        .id_memRead (id_memRead),
        .mem_wait   (mem_wait),
        .flush      (flush),
        .stall_id   (stall_id),
        .fwd_rs_ex  (fwd_rs_ex),
        .fwd_rt_ex  (fwd_rt_ex),
        .sb_state   (sb_state),
        .ldstall_cnt(ldstall_cnt),
        .wait_cnt   (wait_cnt)
    );

    typedef struct {
        bit n, v;
        int rs, rt;
        bit wr;
        int ws;
        bit ld, mw, fl;
        bit es;
        int ers, ert, est, eld, ewt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit n, bit v, int rs, int rt, bit wr, int ws,
                                bit ld, bit mw, bit fl, bit es, int ers,
                                int ert, int est, int eld, int ewt);
        vec_t r;
        r.n = n; r.v = v; r.rs = rs; r.rt = rt; r.wr = wr; r.ws = ws;
        r.ld = ld; r.mw = mw; r.fl = fl; r.es = es; r.ers = ers;
        r.ert = ert; r.est = est; r.eld = eld; r.ewt = ewt;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit n, input bit v, input int rs, input int rt,
                         input bit wr, input int ws, input bit ld,
                         input bit mw, input bit fl);
        nRST       = n;
        id_valid   = v;
        id_rs      = 5'(rs);
        id_rt      = 5'(rt);
        id_regWr   = wr;
        id_wsel    = 5'(ws);
        id_memRead = ld;
        mem_wait   = mw;
        flush      = fl;
    endtask

    task automatic check_all(input string tag, input int es, input int ers,
                             input int ert, input int est, input int eld,
                             input int ewt);
        check({tag, " stall_id"},    int'(stall_id),    es);
        check({tag, " fwd_rs_ex"},   int'(fwd_rs_ex),   ers);
        check({tag, " fwd_rt_ex"},   int'(fwd_rt_ex),   ert);
        check({tag, " sb_state"},    int'(sb_state),    est);
        check({tag, " ldstall_cnt"}, int'(ldstall_cnt), CNT_EN ? eld : 0);
        check({tag, " wait_cnt"},    int'(wait_cnt),    CNT_EN ? ewt : 0);
    endtask

    // ---------------- reference model: in-flight instructions by age -------
    typedef struct {
        bit valid;
        bit wr;
        int rd;
        bit ld;
    } inst_t;

    inst_t pipe[3];          // age 0 = EX, 1 = MEM, 2 = WB
    int    m_mode;           // 0 run, 1 load stall, 2 memory wait
    int    m_frs, m_frt, m_ldc, m_wtc;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    function automatic bit writes(inst_t i, int src);
        return i.valid && i.wr && i.rd != 0 && i.rd == src;
    endfunction

    function automatic int code_for(int src);
        for (int age = 0; age < 3; age++) begin
            if (writes(pipe[age], src)) begin
                if (age == 0) return pipe[0].ld ? 0 : 1;
                if (age == 1) return 2;
                return 0;
            end
        end
        return 0;
    endfunction

    function automatic bit m_load_use(int rs, int rt);
        return pipe[0].ld && (writes(pipe[0], rs) || writes(pipe[0], rt));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0};
        m_mode = 0; m_frs = 0; m_frt = 0; m_ldc = 0; m_wtc = 0;
    endtask

    task automatic model_edge(input bit n, input bit v, input int rs,
                              input int rt, input bit wr, input int ws,
                              input bit ld, input bit mw, input bit fl);
        inst_t e;
        bit    st;
        if (!n) begin
            model_clear();
        end else begin
            if (m_mode == 2 && m_wtc < CNT_MAX) m_wtc++;
            if (mw) begin
                m_mode = 2;
            end else begin
                st = m_load_use(rs, rt) && !fl;
                if (st && m_ldc < CNT_MAX) m_ldc++;
                e = '{0, 0, 0, 0};
                if (v && !st && !fl) e = '{1, wr, ws, ld};
                m_frs = e.valid ? code_for(rs) : 0;
                m_frt = e.valid ? code_for(rt) : 0;
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = e;
                m_mode = st ? 1 : 0;
            end
        end
    endtask

    initial begin
        // n v rs rt wr ws ld mw fl | stall rs rt state ldc wtc
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); // reset state
        tbl.push_back(mk(1,1,1,2,1,3,0,0,0, 0,0,0,0,0,0)); // add $3
        tbl.push_back(mk(1,1,3,5,1,4,0,0,0, 0,0,0,0,0,0)); // sub $4,$3,$5
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,0,0,0,0)); // EX: rs from MEM
        tbl.push_back(mk(1,1,4,3,1,8,0,0,0, 0,0,0,0,0,0)); // $4 in S1, $3 in S2
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,2,0,0,0,0));
        tbl.push_back(mk(1,1,1,0,1,2,1,0,0, 0,0,0,0,0,0)); // lw $2
        tbl.push_back(mk(1,1,2,2,1,6,0,0,0, 1,0,0,0,0,0)); // add $6,$2,$2 stall
        tbl.push_back(mk(1,1,2,2,1,6,0,0,0, 0,0,0,1,1,0)); // LDSTALL cycle
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,2,2,0,1,0)); // both from WB
        tbl.push_back(mk(1,1,0,0,1,0,1,0,0, 0,0,0,0,1,0)); // lw $0
        tbl.push_back(mk(1,1,0,0,1,1,0,0,0, 0,0,0,0,1,0)); // add $1,$0,$0
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(1,1,0,0,1,2,1,0,0, 0,0,0,0,1,0)); // lw $2
        tbl.push_back(mk(1,1,2,1,1,7,0,0,1, 0,0,0,0,1,0)); // flush add $7,$2,$1
        tbl.push_back(mk(1,1,2,0,1,9,0,0,0, 0,0,0,0,1,0)); // S0 is a bubble
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,2,0,0,1,0));
        tbl.push_back(mk(1,1,1,2,1,3,0,0,0, 0,0,0,0,1,0)); // add $3
        tbl.push_back(mk(1,1,3,5,1,4,0,0,0, 0,0,0,0,1,0)); // sub $4,$3,$5
        tbl.push_back(mk(1,1,4,3,1,10,0,1,0, 1,1,0,0,1,0)); // or + mem_wait
        tbl.push_back(mk(1,1,4,3,1,10,0,1,0, 1,1,0,2,1,0));
        tbl.push_back(mk(1,1,4,3,1,10,0,1,0, 1,1,0,2,1,1));
        tbl.push_back(mk(1,1,4,3,1,10,0,1,0, 1,1,0,2,1,2));
        tbl.push_back(mk(1,1,4,3,1,10,0,0,0, 0,1,0,2,1,3)); // release
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,1,2,0,1,4)); // same codes as no wait
        tbl.push_back(mk(1,1,0,0,1,11,0,0,0, 0,0,0,0,1,4)); // add $11
        tbl.push_back(mk(1,1,11,0,1,12,0,1,0, 1,0,0,0,1,4)); // wait
        tbl.push_back(mk(0,1,11,0,1,12,0,1,0, 1,0,0,2,1,4)); // reset in MWAIT
        tbl.push_back(mk(1,1,11,0,1,12,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0)); // $11 no longer fwd
        tbl.push_back(mk(1,1,0,0,1,5,1,1,1, 1,0,0,0,0,0)); // mem_wait beats flush
        tbl.push_back(mk(1,1,0,0,1,5,1,0,1, 0,0,0,2,0,0)); // flush held, applies
        tbl.push_back(mk(1,1,5,5,1,6,0,0,0, 0,0,0,0,0,1)); // lw $5 was squashed

        drive(0,0,0,0,0,0,0,0,0);
        @(negedge CLK);
        @(negedge CLK);

        foreach (tbl[i]) begin
            drive(tbl[i].n, tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].wr,
                  tbl[i].ws, tbl[i].ld, tbl[i].mw, tbl[i].fl);
            #2;
            check_all($sformatf("vec%0d", i), tbl[i].es, tbl[i].ers,
                      tbl[i].ert, tbl[i].est, tbl[i].eld, tbl[i].ewt);
            @(negedge CLK);
        end

        // Randomized phase against the in-flight model.
        drive(0,0,0,0,0,0,0,0,0);
        @(negedge CLK);
        model_clear();
        for (int c = 0; c < 600; c++) begin
            bit n, v, wr, ld, mw, fl, es;
            int rs, rt, ws;
            n  = ($urandom_range(0, 59) != 0);
            v  = ($urandom_range(0, 4) != 0);
            rs = $urandom_range(0, 3);
            rt = $urandom_range(0, 3);
            ws = $urandom_range(0, 3);
            wr = ($urandom_range(0, 3) != 0);
            ld = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 7) == 0);
            drive(n, v, rs, rt, wr, ws, ld, mw, fl);
            es = mw ? 1'b1 : (m_load_use(rs, rt) && !fl);
            #2;
            check_all($sformatf("rnd%0d", c), int'(es), m_frs, m_frt, m_mode,
                      m_ldc, m_wtc);
            @(negedge CLK);
            model_edge(n, v, rs, rt, wr, ws, ld, mw, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
